// File: rtl/fp_classify_stream_if.sv
//------------------------------------------------------------------------------
// Module : fp_classify_stream_if
// Brief  : Operand/result stream bundle for fp_classify_stream. Carries the
//          input valid/ready/operand, output valid/ready/data/class, and the
//          sticky status flags with their clear strobe.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fp_classify_stream_if #(
    parameter int W = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [9:0]   out_class;
    logic [9:0]   sticky;
    logic         sticky_clr;

    // Operand source / result consumer side
    modport master (
        output in_valid, in, out_ready, sticky_clr,
        input  in_ready, out_valid, out_data, out_class, sticky
    );

    // Classifier side
    modport slave (
        input  in_valid, in, out_ready, sticky_clr,
        output in_ready, out_valid, out_data, out_class, sticky
    );
endinterface

`default_nettype wire

// File: rtl/fp_classify_stream.sv
//------------------------------------------------------------------------------
// Module : fp_classify_stream
// Brief  : One-stage pipelined IEEE-754 classifier for a generic binary format
//          {sign, EXP_W exponent, MAN_W mantissa}. Each accepted operand is
//          returned with a one-hot fclass-ordered 10-bit class vector, and a
//          sticky OR of all transferred classes is kept for status logic.
//          Optional macro FP_CLASSIFY_CNT_EN adds ten saturating per-class
//          event counters readable through cnt_sel/cnt_val.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_classify_stream #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_classify_stream_if.slave  bus
`ifdef FP_CLASSIFY_CNT_EN
    ,
    input  logic [3:0]           cnt_sel,
    output logic [CNT_W-1:0]     cnt_val
`endif
);

    localparam int W = 1 + EXP_W + MAN_W;

    // Class bit positions (fclass order)
    localparam logic [9:0] C_NEG_INF  = 10'h001;
    localparam logic [9:0] C_NEG_NORM = 10'h002;
    localparam logic [9:0] C_NEG_DEN  = 10'h004;
    localparam logic [9:0] C_NEG_ZERO = 10'h008;
    localparam logic [9:0] C_POS_ZERO = 10'h010;
    localparam logic [9:0] C_POS_DEN  = 10'h020;
    localparam logic [9:0] C_POS_NORM = 10'h040;
    localparam logic [9:0] C_POS_INF  = 10'h080;
    localparam logic [9:0] C_SNAN     = 10'h100;
    localparam logic [9:0] C_QNAN     = 10'h200;

    // Narrower fields leave no room for the quiet bit or denormals; such a
    // configuration elaborates this empty marker block and is not supported.
    if (EXP_W < 2 || MAN_W < 2 || CNT_W < 1) begin : g_bad_params
    end

    // Every encoding lands in exactly one class; NaNs ignore the sign bit.
    function automatic logic [9:0] classify(input logic [W-1:0] v);
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        logic [9:0]       c;
        s = v[W-1];
        e = v[W-2 -: EXP_W];
        m = v[MAN_W-1:0];
        if (&e) begin
            if (m == '0) c = s ? C_NEG_INF : C_POS_INF;
            else         c = m[MAN_W-1] ? C_QNAN : C_SNAN;
        end else if (e == '0) begin
            if (m == '0) c = s ? C_NEG_ZERO : C_POS_ZERO;
            else         c = s ? C_NEG_DEN  : C_POS_DEN;
        end else begin
            c = s ? C_NEG_NORM : C_POS_NORM;
        end
        return c;
    endfunction

    logic         r_ready_en;
    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic [9:0]   r_out_class;
    logic [9:0]   r_sticky;

    logic         w_accept;
    logic         w_xfer;
    logic [9:0]   w_class;

    // r_ready_en keeps in_ready low during reset so no source sees a phantom
    // accept; it rises on the first edge after reset is released.
    assign bus.in_ready  = r_ready_en && (!r_out_valid || bus.out_ready);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_xfer        = r_out_valid && bus.out_ready;
    assign w_class       = classify(bus.in);

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_class = r_out_class;
    assign bus.sticky    = r_sticky;

    // Output register stage: load on accept, empty on a transfer with no refill
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready_en  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_class <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.in;
                r_out_class <= w_class;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Sticky flags: clear first, then OR in the class of a coincident transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (bus.sticky_clr) begin
            r_sticky <= w_xfer ? r_out_class : 10'h000;
        end else if (w_xfer) begin
            r_sticky <= r_sticky | r_out_class;
        end
    end

`ifdef FP_CLASSIFY_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt [10];

    // Per-class saturating counters, zeroed by sticky_clr like the flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 10; k++) r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 10; k++) begin
                if (bus.sticky_clr) begin
                    r_cnt[k] <= (w_xfer && r_out_class[k]) ? CNT_ONE : '0;
                end else if (w_xfer && r_out_class[k] && !(&r_cnt[k])) begin
                    r_cnt[k] <= r_cnt[k] + CNT_ONE;
                end
            end
        end
    end

    // Counter readback; unused select codes read as zero
    always_comb begin
        cnt_val = '0;
        if (cnt_sel < 4'd10) cnt_val = r_cnt[cnt_sel];
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_classify_stream.sv
//------------------------------------------------------------------------------
// Module : tb_fp_classify_stream
// Brief  : Scoreboard bench for fp_classify_stream (fp16 and fp32 instances).
//          Counter checks are built when FP_CLASSIFY_CNT_EN is defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp_classify_stream;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fp_classify_stream_if #(.W(16)) bus16 ();
    fp_classify_stream_if #(.W(32)) bus32 ();

`ifdef FP_CLASSIFY_CNT_EN
    logic [3:0]  cnt_sel   = 4'd0;
    logic [3:0]  cnt_val;
    logic [3:0]  cnt_sel32 = 4'd0;
    logic [15:0] cnt_val32;
`endif

    fp_classify_stream #(.EXP_W(5), .MAN_W(10), .CNT_W(4)) u16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus16)
`ifdef FP_CLASSIFY_CNT_EN
        ,
        .cnt_sel (cnt_sel),
        .cnt_val (cnt_val)
`endif
    );

    fp_classify_stream #(.EXP_W(8), .MAN_W(23), .CNT_W(16)) u32 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus32)
`ifdef FP_CLASSIFY_CNT_EN
        ,
        .cnt_sel (cnt_sel32),
        .cnt_val (cnt_val32)
`endif
    );

    // Scoreboards hold {class, data} expected at the output
    logic [25:0] sb16 [$];
    logic [41:0] sb32 [$];
    logic [9:0]  cur_cls16;
    logic [9:0]  cur_cls32;

    logic [15:0] c16_in [10] = '{16'hFC00, 16'hBC00, 16'h8001, 16'h8000, 16'h0000,
                                 16'h0001, 16'h3C00, 16'h7C00, 16'h7D00, 16'h7E00};
    logic [9:0]  c16_cl [10] = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010,
                                 10'h020, 10'h040, 10'h080, 10'h100, 10'h200};
    logic [31:0] c32_in [4]  = '{32'h7FC00000, 32'h7F800001, 32'h00000001, 32'hFF800000};
    logic [9:0]  c32_cl [4]  = '{10'h200, 10'h100, 10'h020, 10'h001};

    task automatic drive16(input logic v, input logic [15:0] d, input logic [9:0] c);
        bus16.in_valid = v;
        bus16.in       = d;
        cur_cls16      = c;
    endtask

    task automatic drive32(input logic v, input logic [31:0] d, input logic [9:0] c);
        bus32.in_valid = v;
        bus32.in       = d;
        cur_cls32      = c;
    endtask

    // Records the expected result of an accept seen at the sampling point
    task automatic note_accept16();
        if (bus16.in_valid && bus16.in_ready) sb16.push_back({cur_cls16, bus16.in});
    endtask

    task automatic note_accept32();
        if (bus32.in_valid && bus32.in_ready) sb32.push_back({cur_cls32, bus32.in});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus16.out_valid !== 1'b0 || bus16.out_data !== 16'h0 ||
            bus16.out_class !== 10'h0 || bus16.sticky !== 10'h0) begin
            bad++;
            $display("FAIL reset16: valid=%b data=%h class=%h sticky=%h, want 0 0000 000 000",
                     bus16.out_valid, bus16.out_data, bus16.out_class, bus16.sticky);
        end
        total++;
        if (bus32.out_valid !== 1'b0 || bus32.out_class !== 10'h0) begin
            bad++;
            $display("FAIL reset32: valid=%b class=%h, want 0 000", bus32.out_valid, bus32.out_class);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        next_cycle();
        total++;
        if (bus16.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b want 1", bus16.in_ready);
        end
    endtask

    task automatic test_classes();
        logic [25:0] e;
        int seen = 0;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i < 10) drive16(1'b1, c16_in[i], c16_cl[i]);
            else        drive16(1'b0, 16'h0, 10'h0);
            @(negedge clk);
            if (i == 0) begin
                total++;
                if (bus16.out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL latency_pre: out_valid=%b want 0", bus16.out_valid);
                end
            end
            if (i == 1) begin
                total++;
                if (bus16.out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL latency_first: out_valid=%b want 1", bus16.out_valid);
                end
            end
            if (bus16.out_valid && bus16.out_ready) begin
                total++;
                if (sb16.size() == 0) begin
                    bad++;
                    $display("FAIL classes_extra: unexpected output %h", bus16.out_data);
                end else begin
                    e = sb16.pop_front();
                    seen++;
                    if ({bus16.out_class, bus16.out_data} !== e) begin
                        bad++;
                        $display("FAIL classes_beat: got class=%h data=%h want class=%h data=%h",
                                 bus16.out_class, bus16.out_data, e[25:16], e[15:0]);
                    end
                end
            end
            note_accept16();
            next_cycle();
        end
        total++;
        if (seen != 10 || sb16.size() != 0) begin
            bad++;
            $display("FAIL classes_count: got %0d beats (%0d left) want 10 (0 left)", seen, sb16.size());
        end
        total++;
        if (bus16.sticky !== 10'h3FF) begin
            bad++;
            $display("FAIL classes_sticky: got %h want 3ff", bus16.sticky);
        end
    endtask

    task automatic test_fp32();
        logic [41:0] e;
        int seen = 0;
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive32(1'b1, c32_in[i], c32_cl[i]);
            else       drive32(1'b0, 32'h0, 10'h0);
            @(negedge clk);
            if (bus32.out_valid && bus32.out_ready) begin
                total++;
                if (sb32.size() == 0) begin
                    bad++;
                    $display("FAIL fp32_extra: unexpected output %h", bus32.out_data);
                end else begin
                    e = sb32.pop_front();
                    seen++;
                    if ({bus32.out_class, bus32.out_data} !== e) begin
                        bad++;
                        $display("FAIL fp32_beat: got class=%h data=%h want class=%h data=%h",
                                 bus32.out_class, bus32.out_data, e[41:32], e[31:0]);
                    end
                end
            end
            note_accept32();
            next_cycle();
        end
        total++;
        if (seen != 4) begin
            bad++;
            $display("FAIL fp32_count: got %0d beats want 4", seen);
        end
    endtask

    task automatic test_backpressure();
        logic [25:0] e;
        bus16.out_ready = 1'b1;
        drive16(1'b1, 16'h3C00, 10'h040);
        @(negedge clk);
        note_accept16();
        next_cycle();
        bus16.out_ready = 1'b0;
        drive16(1'b1, 16'h7C00, 10'h080);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1 ||
                bus16.out_data !== 16'h3C00 || bus16.out_class !== 10'h040) begin
                bad++;
                $display("FAIL stall_hold: ready=%b valid=%b data=%h class=%h want 0 1 3c00 040",
                         bus16.in_ready, bus16.out_valid, bus16.out_data, bus16.out_class);
            end
            note_accept16();
            next_cycle();
        end
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus16.out_valid && bus16.out_ready) begin
                total++;
                if (sb16.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra: unexpected output %h", bus16.out_data);
                end else begin
                    e = sb16.pop_front();
                    if ({bus16.out_class, bus16.out_data} !== e) begin
                        bad++;
                        $display("FAIL bp_beat: got class=%h data=%h want class=%h data=%h",
                                 bus16.out_class, bus16.out_data, e[25:16], e[15:0]);
                    end
                end
            end
            note_accept16();
            next_cycle();
            drive16(1'b0, 16'h0, 10'h0);
        end
        total++;
        if (sb16.size() != 0 || bus16.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: left=%0d valid=%b want 0 0", sb16.size(), bus16.out_valid);
        end
    endtask

    task automatic test_sticky();
        logic [25:0] e;
        bus16.out_ready  = 1'b1;
        drive16(1'b0, 16'h0, 10'h0);
        bus16.sticky_clr = 1'b1;
        next_cycle();
        bus16.sticky_clr = 1'b0;
        total++;
        if (bus16.sticky !== 10'h000) begin
            bad++;
            $display("FAIL sticky_clr_idle0: got %h want 000", bus16.sticky);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive16(1'b1, 16'h7E00, 10'h200);
            if (i == 1) drive16(1'b1, 16'h0000, 10'h010);
            if (i == 2) begin
                drive16(1'b0, 16'h0, 10'h0);
                bus16.sticky_clr = 1'b1;
            end
            @(negedge clk);
            if (bus16.out_valid && bus16.out_ready) begin
                total++;
                e = sb16.pop_front();
                if ({bus16.out_class, bus16.out_data} !== e) begin
                    bad++;
                    $display("FAIL sticky_beat: got class=%h data=%h want class=%h data=%h",
                             bus16.out_class, bus16.out_data, e[25:16], e[15:0]);
                end
            end
            note_accept16();
            next_cycle();
            if (i == 1) begin
                total++;
                if (bus16.sticky !== 10'h200) begin
                    bad++;
                    $display("FAIL sticky_or: got %h want 200", bus16.sticky);
                end
            end
        end
        bus16.sticky_clr = 1'b0;
        total++;
        if (bus16.sticky !== 10'h010) begin
            bad++;
            $display("FAIL sticky_clr_xfer: got %h want 010", bus16.sticky);
        end
        bus16.sticky_clr = 1'b1;
        next_cycle();
        bus16.sticky_clr = 1'b0;
        total++;
        if (bus16.sticky !== 10'h000 || bus16.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL sticky_clr_idle: sticky=%h valid=%b want 000 0", bus16.sticky, bus16.out_valid);
        end
    endtask

`ifdef FP_CLASSIFY_CNT_EN
    task automatic test_counters();
        logic [25:0] e;
        bus16.out_ready  = 1'b1;
        drive16(1'b0, 16'h0, 10'h0);
        bus16.sticky_clr = 1'b1;
        next_cycle();
        bus16.sticky_clr = 1'b0;
        for (int i = 0; i < 22; i++) begin
            if (i < 20) drive16(1'b1, 16'h3C00, 10'h040);
            else        drive16(1'b0, 16'h0, 10'h0);
            @(negedge clk);
            if (bus16.out_valid && bus16.out_ready) begin
                total++;
                e = sb16.pop_front();
                if ({bus16.out_class, bus16.out_data} !== e) begin
                    bad++;
                    $display("FAIL cnt_beat: got class=%h data=%h want class=%h data=%h",
                             bus16.out_class, bus16.out_data, e[25:16], e[15:0]);
                end
            end
            note_accept16();
            next_cycle();
        end
        cnt_sel = 4'd6; #1;
        total++;
        if (cnt_val !== 4'd15) begin
            bad++;
            $display("FAIL cnt_saturate: got %0d want 15", cnt_val);
        end
        cnt_sel = 4'd7; #1;
        total++;
        if (cnt_val !== 4'd0) begin
            bad++;
            $display("FAIL cnt_other: got %0d want 0", cnt_val);
        end
        cnt_sel = 4'd12; #1;
        total++;
        if (cnt_val !== 4'd0) begin
            bad++;
            $display("FAIL cnt_sel12: got %0d want 0", cnt_val);
        end
        bus16.sticky_clr = 1'b1;
        next_cycle();
        bus16.sticky_clr = 1'b0;
        cnt_sel = 4'd6; #1;
        total++;
        if (cnt_val !== 4'd0) begin
            bad++;
            $display("FAIL cnt_clear: got %0d want 0", cnt_val);
        end
    endtask
`endif

    task automatic test_reset_stall();
        bus16.out_ready = 1'b1;
        drive16(1'b1, 16'h0001, 10'h020);
        next_cycle();
        drive16(1'b1, 16'h3C00, 10'h040);
        next_cycle();
        drive16(1'b0, 16'h0, 10'h0);
        bus16.out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus16.out_valid !== 1'b1 || bus16.out_data !== 16'h3C00 || bus16.sticky !== 10'h020) begin
            bad++;
            $display("FAIL stall_setup: valid=%b data=%h sticky=%h want 1 3c00 020",
                     bus16.out_valid, bus16.out_data, bus16.sticky);
        end
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        sb16.delete();
        @(negedge clk);
        total++;
        if (bus16.out_valid !== 1'b0 || bus16.sticky !== 10'h000 || bus16.out_class !== 10'h000) begin
            bad++;
            $display("FAIL reset_stall: valid=%b sticky=%h class=%h want 0 000 000",
                     bus16.out_valid, bus16.sticky, bus16.out_class);
        end
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            total++;
            if (bus16.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_discard: out_valid=%b data=%h want 0", bus16.out_valid, bus16.out_data);
            end
        end
    endtask

    initial begin
        bus16.in_valid = 1'b0; bus16.in = '0; bus16.out_ready = 1'b0; bus16.sticky_clr = 1'b0;
        bus32.in_valid = 1'b0; bus32.in = '0; bus32.out_ready = 1'b0; bus32.sticky_clr = 1'b0;
        cur_cls16 = '0;
        cur_cls32 = '0;
        test_reset();
        test_classes();
        test_fp32();
        test_backpressure();
        test_sticky();
`ifdef FP_CLASSIFY_CNT_EN
        test_counters();
`endif
        test_reset_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
